// File: rtl/sel_func_pipe.sv
// Purpose : single-stage select-function ALU (logic ops, add, sub, accumulate) with a registered E/C/Z result.
// Latency : a request accepted at edge N is presented on E/C/Z with out_valid=1 right after edge N.
// Backpress: one result register; in_ready = !out_valid || out_ready, so a stalled result blocks new requests.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  request handshake; s, A, B sampled on accept
//   out_valid / out_ready result handshake; E result, C carry/borrow, Z zero flag
module sel_func_pipe #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   s,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] E,
    output logic         C,
    output logic         Z
);

    logic         valid_q, valid_d;
    logic [W-1:0] e_q, e_d;
    logic         c_q, c_d;
    logic         z_q, z_d;
    logic [W-1:0] acc_q, acc_d;

    logic         accept;
    logic         consume;
    logic [W:0]   res;      // bit W carries the carry/borrow
    logic [W-1:0] acc_new;  // accumulator value implied by this op
    logic [W:0]   sum_ab;
    logic [W:0]   diff_ab;
    logic [W:0]   sum_acc;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign consume  = valid_q && out_ready;

    // W+1-bit arithmetic: the extra bit is carry-out for add and borrow for
    // subtract (two's-complement wrap sets bit W exactly when A < B).
    assign sum_ab  = {1'b0, A} + {1'b0, B};
    assign diff_ab = {1'b0, A} - {1'b0, B};
    assign sum_acc = {1'b0, acc_q} + {1'b0, A};

    always_comb begin
        res     = '0;
        acc_new = acc_q;
        case (s)
            3'b000: res = {1'b0, A & B};
            3'b001: res = {1'b0, A | B};
            3'b010: res = {1'b0, A ^ B};
            3'b011: res = {1'b0, ~A};
            3'b100: res = sum_ab;
            3'b101: res = diff_ab;
            3'b110: begin
                res     = sum_acc;
                acc_new = sum_acc[W-1:0];
            end
            3'b111: begin
                res     = '0;
                acc_new = '0;
            end
            default: res = '0;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        e_d     = e_q;
        c_d     = c_q;
        z_d     = z_q;
        acc_d   = acc_q;
        if (accept) begin
            // Accept wins over consume: simultaneous handshakes keep out_valid high.
            valid_d = 1'b1;
            e_d     = res[W-1:0];
            c_d     = res[W];
            z_d     = (res[W-1:0] == '0);  // from the new result, never the held one
            acc_d   = acc_new;
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            e_q     <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            acc_q   <= '0;
        end else begin
            valid_q <= valid_d;
            e_q     <= e_d;
            c_q     <= c_d;
            z_q     <= z_d;
            acc_q   <= acc_d;
        end
    end

    assign out_valid = valid_q;
    assign E         = e_q;
    assign C         = c_q;
    assign Z         = z_q;

endmodule

// File: tb/tb_sel_func_pipe.sv
module tb_sel_func_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  s;
    logic [7:0]  A, B;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  E;
    logic        C, Z;

    logic [15:0] A16, B16;
    logic        in_ready16, out_valid16;
    logic [15:0] E16;
    logic        C16, Z16;

    int errors = 0;
    int checks = 0;

    // behavioural model state (W=8)
    bit m_valid;
    int m_e, m_c, m_z, m_acc;

    always #5 clk = ~clk;

    sel_func_pipe #(.W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .s(s), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .E(E), .C(C), .Z(Z)
    );

    sel_func_pipe #(.W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
        .s(s), .A(A16), .B(B16), .out_valid(out_valid16), .out_ready(out_ready),
        .E(E16), .C(C16), .Z(Z16)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: results computed with plain integer arithmetic from the op table.
    always @(negedge rst_n) begin
        m_valid = 0; m_e = 0; m_c = 0; m_z = 0; m_acc = 0;
    end

    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            int a, b, t;
            bit acc_ok;
            a = A; b = B;
            acc_ok = in_valid && (!m_valid || out_ready);
            if (acc_ok) begin
                m_c = 0;
                case (s)
                    3'd0: m_e = a & b;
                    3'd1: m_e = a | b;
                    3'd2: m_e = a ^ b;
                    3'd3: m_e = 255 - a;
                    3'd4: begin t = a + b; m_e = t % 256; m_c = (t > 255); end
                    3'd5: begin m_e = (a - b + 256) % 256; m_c = (a < b); end
                    3'd6: begin t = m_acc + a; m_acc = t % 256; m_e = m_acc; m_c = (t > 255); end
                    default: begin m_acc = 0; m_e = 0; end
                endcase
                m_z = (m_e == 0);
                m_valid = 1;
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
    end

    // Compare process: every falling edge, away from the active edge.
    always @(negedge clk) begin
        chk("in_ready", in_ready, (!m_valid || out_ready));
        chk("out_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("E", E, m_e);
            chk("C", C, m_c);
            chk("Z", Z, m_z);
        end
    end

    task automatic tick(input logic v, input logic [2:0] sel, input logic [7:0] a,
                        input logic [7:0] b, input logic ordy);
        in_valid = v; s = sel; A = a; B = b; out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [7:0] e, input logic c, input logic z);
        chk({name, ".vld"}, out_valid, 1'b1);
        chk({name, ".E"}, E, e);
        chk({name, ".C"}, C, c);
        chk({name, ".Z"}, Z, z);
    endtask

    initial begin
        rst_n = 1'b1; in_valid = 1'b1; s = 3'd4; A = 8'h11; B = 8'h22; out_ready = 1'b0;
        A16 = 16'h0; B16 = 16'h0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst.vld", out_valid, 1'b0);
        chk("rst.E", E, 8'h00);
        chk("rst.C", C, 1'b0);
        chk("rst.Z", Z, 1'b0);
        chk("rst.in_ready", in_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.hold_vld", out_valid, 1'b0);
        rst_n = 1'b1;

        // logic ops back to back; first edge after release accepts
        tick(1, 3'd0, 8'h0F, 8'h3C, 1); lit("and", 8'h0C, 0, 0);
        tick(1, 3'd1, 8'h0F, 8'h3C, 1); lit("or",  8'h3F, 0, 0);
        tick(1, 3'd2, 8'h0F, 8'h3C, 1); lit("xor", 8'h33, 0, 0);
        tick(1, 3'd3, 8'h0F, 8'h3C, 1); lit("not", 8'hF0, 0, 0);

        // add wrap and subtract borrow
        tick(1, 3'd4, 8'hFF, 8'h01, 1); lit("add_wrap", 8'h00, 1, 1);
        tick(1, 3'd5, 8'h02, 8'h05, 1); lit("sub_brw", 8'hFD, 1, 0);
        tick(1, 3'd5, 8'h05, 8'h05, 1); lit("sub_eq", 8'h00, 0, 1);

        // accumulator
        tick(1, 3'd7, 8'hAA, 8'h55, 1); lit("clr", 8'h00, 0, 1);
        tick(1, 3'd6, 8'h80, 8'hFF, 1); lit("acc1", 8'h80, 0, 0);
        tick(1, 3'd6, 8'h90, 8'hFF, 1); lit("acc2", 8'h10, 1, 0);
        tick(1, 3'd6, 8'h05, 8'h00, 1); lit("acc3", 8'h15, 0, 0);
        tick(1, 3'd7, 8'h12, 8'h34, 1); lit("clr2", 8'h00, 0, 1);
        tick(1, 3'd6, 8'h15, 8'h00, 1); lit("acc4", 8'h15, 0, 0);

        // stall: result pending, in_valid high, out_ready low
        for (int i = 0; i < 3; i++) begin
            tick(1, 3'd6, 8'h10, 8'h00, 0);
            chk("stall.in_ready", in_ready, 1'b0);
            lit("stall", 8'h15, 0, 0);
        end
        // consume and accept on the same edge; ACC still 0x15
        tick(1, 3'd6, 8'h01, 8'h00, 1); lit("cons_acc", 8'h16, 0, 0);
        tick(1, 3'd0, 8'hFF, 8'hAA, 1); lit("and2", 8'hAA, 0, 0);
        tick(1, 3'd1, 8'h01, 8'h02, 0); lit("stall2", 8'hAA, 0, 0);

        // mid-cycle reset drops a stalled result immediately
        #2 rst_n = 1'b0;
        #1;
        chk("mrst.vld", out_valid, 1'b0);
        chk("mrst.E", E, 8'h00);
        chk("mrst.C", C, 1'b0);
        chk("mrst.Z", Z, 1'b0);
        chk("mrst.in_ready", in_ready, 1'b1);
        #1 rst_n = 1'b1;
        tick(1, 3'd6, 8'h01, 8'h00, 1); lit("post_rst_acc", 8'h01, 0, 0);
        tick(0, 3'd0, 8'h00, 8'h00, 1);
        chk("idle.vld", out_valid, 1'b0);

        // W=16 instance
        A16 = 16'hFFFF; B16 = 16'h0002;
        tick(1, 3'd4, 8'h00, 8'h00, 1);
        chk("w16.add.E", E16, 16'h0001);
        chk("w16.add.C", C16, 1'b1);
        chk("w16.add.Z", Z16, 1'b0);
        A16 = 16'h00FF; B16 = 16'h1234;
        tick(1, 3'd3, 8'h00, 8'h00, 1);
        chk("w16.not.E", E16, 16'hFF00);
        chk("w16.not.C", C16, 1'b0);
        tick(0, 3'd0, 8'h00, 8'h00, 1);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sel_func_pipe.md
SEL_FUNC_PIPE -- requirements
Module: sel_func_pipe

Interface
REQ-001 Parameter W, default 8: operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 s  input  3  function select, {s2,s1,s0} order, s[2] MSB.
REQ-007 A  input  W  first operand, unsigned.
REQ-008 B  input  W  second operand, unsigned.
REQ-009 out_valid  output  1  E/C/Z hold a result not yet consumed.
REQ-010 out_ready  input  1  downstream consumes the result this cycle.
REQ-011 E  output  W  registered result.
REQ-012 C  output  1  registered carry/borrow flag.
REQ-013 Z  output  1  registered zero flag; 1 when E == 0.

Function
REQ-014 Accept = in_valid && in_ready; all inputs are sampled only on an accept edge.
REQ-015 in_ready = !out_valid || out_ready, combinationally; no other path to in_ready.
REQ-016 Latency: a request accepted at edge N makes out_valid = 1 with its result after edge N; one-cycle latency, one result register, no internal queue.
REQ-017 Consume = out_valid && out_ready; on consume without accept, out_valid clears at the next edge.
REQ-018 Simultaneous consume and accept: out_valid stays 1 and E/C/Z load the new result; back-to-back throughput is one op per cycle.
REQ-019 While out_valid && !out_ready: E, C, Z and out_valid hold stable; no request is accepted.
REQ-020 s = 000: E = A & B, C = 0.
REQ-021 s = 001: E = A | B, C = 0.
REQ-022 s = 010: E = A ^ B, C = 0.
REQ-023 s = 011: E = ~A, C = 0.
REQ-024 s = 100: E = (A + B) mod 2^W, C = carry out of bit W-1.
REQ-025 s = 101: E = (A - B) mod 2^W, C = 1 exactly when A < B (borrow).
REQ-026 s = 110: internal W-bit accumulator ACC <= (ACC + A) mod 2^W; E = new ACC value; C = carry out; B ignored.
REQ-027 s = 111: ACC <= 0; E = 0, C = 0, Z = 1; A and B ignored.
REQ-028 ACC changes only on accept with s = 110 or 111; it holds through stalls, idle cycles and all other ops.
REQ-029 Z is computed from the new E in the same edge E loads; it is never computed from a stale value.
REQ-030 Arithmetic is evaluated at W+1 bits; wrap-around is modulo 2^W with no saturation, and overflow is flagged only through C.

Reset
REQ-031 rst_n low forces immediately, without waiting for clk: out_valid = 0, E = 0, C = 0, Z = 0, ACC = 0.
REQ-032 While rst_n is low, in_ready = 1 and no request is accepted.
REQ-033 Reset during a stalled result discards that result; after release the block is idle with in_ready = 1.
REQ-034 The first edge after rst_n rises can accept a request.

Verification
REQ-035 W=8, A=0x0F, B=0x3C, s=000..011, out_ready=1 -> E = 0x0C, 0x3F, 0x33, 0xF0 on consecutive cycles, C=0, out_valid continuous.
REQ-036 W=8, s=100, A=0xFF, B=0x01 -> E=0x00, C=1, Z=1; then s=101, A=0x02, B=0x05 -> E=0xFD, C=1, Z=0.
REQ-037 s=111, then s=110 with A=0x80, 0x90, 0x05 -> E=0x80 (C=0), 0x10 (C=1), 0x15 (C=0); then s=111 -> E=0, Z=1.
REQ-038 Result pending with out_ready=0 for 3 cycles and in_valid=1 -> in_ready=0, E stable, ACC unchanged; out_ready=1 -> consume and accept on the same edge, next result appears next cycle.
REQ-039 ACC=0x15 and a stalled result pending; pulse rst_n low mid-cycle -> out_valid, E, C, Z drop to 0 before the next edge; after release, s=110 with A=0x01 -> E=0x01.
REQ-040 W=16 build, s=100, A=0xFFFF, B=0x0002 -> E=0x0001, C=1; s=011, A=0x00FF -> E=0xFF00.
